// File: rtl/puf_meas_ctrl.sv
// puf_meas_ctrl: measurement sequencer for the ring-oscillator PUF datapath.
// For each of NBITS challenge bits it clears both bank counters, enables the
// oscillators for a programmable window, waits for the ripple counters to
// settle, then compares the two counts and stores one response bit.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   start, abort    begin a run (sampled in IDLE) / cancel a run in progress
//   chal            challenge seed: [SEL_W-1:0] base A, [2*SEL_W-1:SEL_W] base B
//   win_len         oscillation window in clk cycles (0 treated as 1)
//   cnt_a, cnt_b    bank counter values
//   osc_en, cnt_clr oscillator enable / counter clear to both banks
//   sel_a, sel_b    bank oscillator selects
//   busy, done      run in progress / one-cycle run-complete pulse
//   response, tie   response word / sticky equal-count flag for the last run
module puf_meas_ctrl #(
  parameter int unsigned NBITS      = 8,
  parameter int unsigned SEL_W      = 3,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned WIN_W      = 16,
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [2*SEL_W-1:0] chal,
  input  logic [WIN_W-1:0]   win_len,
  input  logic [CNT_W-1:0]   cnt_a,
  input  logic [CNT_W-1:0]   cnt_b,
  output logic               osc_en,
  output logic               cnt_clr,
  output logic [SEL_W-1:0]   sel_a,
  output logic [SEL_W-1:0]   sel_b,
  output logic               busy,
  output logic               done,
  output logic [NBITS-1:0]   response,
  output logic               tie
);

  localparam int unsigned KW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [WIN_W-1:0] SettleLd = WIN_W'(SETTLE_CYC);
  localparam logic [KW-1:0]    KLast    = KW'(NBITS - 1);

  typedef enum logic [2:0] {StIdle, StClear, StRun, StSettle, StCompare, StDone} state_e;

  state_e               state_q, state_d;
  logic [KW-1:0]        k_q, k_d;
  logic [2*SEL_W-1:0]   chal_q, chal_d;
  logic [WIN_W-1:0]     win_q, win_d;
  logic [WIN_W-1:0]     tmr_q, tmr_d;
  logic                 osc_en_q, osc_en_d;
  logic                 cnt_clr_q, cnt_clr_d;
  logic [SEL_W-1:0]     sel_a_q, sel_a_d;
  logic [SEL_W-1:0]     sel_b_q, sel_b_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [NBITS-1:0]     response_q, response_d;
  logic                 tie_q, tie_d;

  // Select pair for bit k, returned as {sel_b, sel_a}. Bank B is nudged off
  // bank A when they collide so the two banks never measure the same ring.
  function automatic logic [2*SEL_W-1:0] sel_pair(input logic [2*SEL_W-1:0] c,
                                                  input logic [KW-1:0] k);
    logic [SEL_W-1:0] a, b;
    a = c[SEL_W-1:0] + SEL_W'(k);
    b = c[2*SEL_W-1:SEL_W] + SEL_W'(k);
    if (a == b) b = a + SEL_W'(1);
    return {b, a};
  endfunction

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    chal_d     = chal_q;
    win_d      = win_q;
    tmr_d      = tmr_q;
    sel_a_d    = sel_a_q;
    sel_b_d    = sel_b_q;
    response_d = response_q;
    tie_d      = tie_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          chal_d               = chal;
          win_d                = (win_len == '0) ? WIN_W'(1) : win_len;
          k_d                  = '0;
          response_d           = '0;
          tie_d                = 1'b0;
          {sel_b_d, sel_a_d}   = sel_pair(chal, '0);
          state_d              = StClear;
        end
      end
      StClear: begin
        tmr_d   = win_q;
        state_d = StRun;
      end
      StRun: begin
        if (tmr_q == WIN_W'(1)) begin
          tmr_d   = SettleLd;
          state_d = StSettle;
        end else begin
          tmr_d = tmr_q - WIN_W'(1);
        end
      end
      StSettle: begin
        if (tmr_q == WIN_W'(1)) begin
          state_d = StCompare;
        end else begin
          tmr_d = tmr_q - WIN_W'(1);
        end
      end
      StCompare: begin
        response_d[k_q] = (cnt_a > cnt_b);
        if (cnt_a == cnt_b) tie_d = 1'b1;
        if (k_q == KLast) begin
          state_d = StDone;
        end else begin
          k_d                = k_q + KW'(1);
          {sel_b_d, sel_a_d} = sel_pair(chal_q, k_q + KW'(1));
          state_d            = StClear;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Abort wins over everything, including this cycle's COMPARE write.
    if (abort && (state_q != StIdle)) begin
      state_d    = StIdle;
      k_d        = k_q;
      sel_a_d    = sel_a_q;
      sel_b_d    = sel_b_q;
      response_d = response_q;
      tie_d      = tie_q;
    end

    // Outputs are decoded from the next state so they register glitch-free
    // and line up exactly with the state they describe.
    osc_en_d  = (state_d == StRun);
    cnt_clr_d = (state_d == StClear);
    busy_d    = (state_d != StIdle);
    done_d    = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      k_q        <= '0;
      chal_q     <= '0;
      win_q      <= '0;
      tmr_q      <= '0;
      osc_en_q   <= 1'b0;
      cnt_clr_q  <= 1'b0;
      sel_a_q    <= '0;
      sel_b_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      response_q <= '0;
      tie_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      chal_q     <= chal_d;
      win_q      <= win_d;
      tmr_q      <= tmr_d;
      osc_en_q   <= osc_en_d;
      cnt_clr_q  <= cnt_clr_d;
      sel_a_q    <= sel_a_d;
      sel_b_q    <= sel_b_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      response_q <= response_d;
      tie_q      <= tie_d;
    end
  end

  assign osc_en   = osc_en_q;
  assign cnt_clr  = cnt_clr_q;
  assign sel_a    = sel_a_q;
  assign sel_b    = sel_b_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign response = response_q;
  assign tie      = tie_q;

endmodule

// File: tb/tb_puf_meas_ctrl.sv
// Scoreboard bench for puf_meas_ctrl: the driver pushes expected selects and
// run results computed from the challenge rules; a monitor pops and compares
// them whenever the DUT clears the counters or pulses done.
module tb_puf_meas_ctrl;
  localparam int NB = 8;
  localparam int SETTLE = 4;

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic [5:0] chal;
  logic [15:0] win_len;
  logic [7:0] cnt_a, cnt_b;
  logic       osc_en, cnt_clr, busy, done, tie;
  logic [2:0] sel_a, sel_b;
  logic [7:0] response;

  puf_meas_ctrl #(
    .NBITS(NB), .SEL_W(3), .CNT_W(8), .WIN_W(16), .SETTLE_CYC(SETTLE)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .chal(chal),
    .win_len(win_len), .cnt_a(cnt_a), .cnt_b(cnt_b), .osc_en(osc_en),
    .cnt_clr(cnt_clr), .sel_a(sel_a), .sel_b(sel_b), .busy(busy),
    .done(done), .response(response), .tie(tie)
  );

  always #5 clk = ~clk;

  typedef struct { logic [2:0] a; logic [2:0] b; } sel_t;
  typedef struct { logic [7:0] resp; logic tie; int lat; } res_t;

  sel_t sel_q[$];
  res_t exp_q[$];
  int errors = 0, checks = 0;
  int cyc = 0, start_cyc = 0, done_cnt = 0, osc_run = 0, exp_win = 1;
  int bank_k = -1;
  bit quiet = 1'b0;
  logic [7:0] ta[NB], tbv[NB];
  sel_t ms;
  res_t mr;

  always @(posedge clk) cyc++;

  // Bank model: counts depend on which bit is being measured.
  always_comb begin
    cnt_a = 8'd0;
    cnt_b = 8'd0;
    if (bank_k >= 0 && bank_k < NB) begin
      cnt_a = ta[bank_k];
      cnt_b = tbv[bank_k];
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Reference: selects, response and tie for the first nb bits of a run.
  task automatic model(input logic [5:0] c, input int nb, input bit push,
                       output logic [7:0] resp, output logic t);
    sel_t s;
    resp = 8'h00;
    t = 1'b0;
    for (int k = 0; k < nb; k++) begin
      s.a = 3'((int'(c[2:0]) + k) % 8);
      s.b = 3'((int'(c[5:3]) + k) % 8);
      if (s.a == s.b) s.b = 3'((int'(s.a) + 1) % 8);
      if (push) sel_q.push_back(s);
      if (ta[k] > tbv[k]) resp[k] = 1'b1;
      if (ta[k] == tbv[k]) t = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (osc_en || cnt_clr) check("osc_clr_exclusive", {31'd0, osc_en & cnt_clr}, 0);
      if (cnt_clr) begin
        bank_k++;
        if (sel_q.size() == 0) check("unexpected_clear", 1, 0);
        else begin
          ms = sel_q.pop_front();
          check("sel_a", {29'd0, sel_a}, {29'd0, ms.a});
          check("sel_b", {29'd0, sel_b}, {29'd0, ms.b});
        end
      end
      if (osc_en) osc_run++;
      else if (osc_run != 0) begin
        if (!quiet) check("osc_window_len", osc_run, exp_win);
        osc_run = 0;
      end
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) check("unexpected_done", 1, 0);
        else begin
          mr = exp_q.pop_front();
          check("response", {24'd0, response}, {24'd0, mr.resp});
          check("tie", {31'd0, tie}, {31'd0, mr.tie});
          check("done_latency", cyc - start_cyc, mr.lat);
          check("busy_in_done", {31'd0, busy}, 1);
        end
      end
    end
  end

  task automatic check_reset_outs(input string tag);
    check({tag, "_osc_en"}, {31'd0, osc_en}, 0);
    check({tag, "_cnt_clr"}, {31'd0, cnt_clr}, 0);
    check({tag, "_sel"}, {26'd0, sel_b, sel_a}, 0);
    check({tag, "_busy_done"}, {30'd0, busy, done}, 0);
    check({tag, "_response_tie"}, {23'd0, response, tie}, 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3000) begin @(negedge clk); n++; end
    if (busy) check("idle_timeout", 1, 0);
  endtask

  // Issue a start; returns after the start-sampling edge.
  task automatic issue(input logic [5:0] c, input logic [15:0] w, input bit push);
    logic [7:0] r;
    logic t;
    res_t e;
    wait_idle();
    @(negedge clk);
    model(c, NB, push, r, t);
    e.resp = r; e.tie = t; e.lat = NB * (2 + ((w == 0) ? 1 : int'(w)) + SETTLE);
    if (push) exp_q.push_back(e);
    exp_win = (w == 0) ? 1 : int'(w);
    quiet = 1'b0;
    bank_k = -1;
    chal = c; win_len = w; start = 1'b1;
    @(posedge clk); #1;
    start_cyc = cyc;
  endtask

  task automatic do_run(input logic [5:0] c, input logic [15:0] w, input bit hold);
    int d0, n;
    d0 = done_cnt;
    issue(c, w, 1'b1);
    if (!hold) start = 1'b0;
    n = 0;
    do begin
      @(negedge clk); n++;
      if (hold && n == 20) begin chal = ~c; win_len = 16'd3; end
    end while (!done && n < 3000);
    if (!done) check("done_timeout", 0, 1);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("one_done_pulse", done_cnt - d0, 1);
    check("idle_after_run", {31'd0, busy}, 0);
  endtask

  task automatic wait_bit_run(input int k);
    int n = 0;
    while (!(bank_k == k && osc_en) && n < 3000) begin @(negedge clk); n++; end
    if (!(bank_k == k && osc_en)) check("wait_bit_timeout", 0, 1);
  endtask

  task automatic rand_tables(input int hi);
    for (int k = 0; k < NB; k++) begin
      ta[k] = 8'($urandom_range(0, hi));
      tbv[k] = 8'($urandom_range(0, hi));
    end
  endtask

  initial begin
    logic [7:0] pr;
    logic pt;
    int d0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; chal = '0; win_len = '0;
    for (int k = 0; k < NB; k++) begin ta[k] = 0; tbv[k] = 0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outs("reset");
    rst = 1'b0;

    // Full run: alternating bank winners.
    for (int k = 0; k < NB; k++) begin
      ta[k]  = (k % 2 == 0) ? 8'd20 : 8'd12;
      tbv[k] = (k % 2 == 0) ? 8'd15 : 8'd30;
    end
    do_run(6'b010_000, 16'd10, 1'b0);
    check("full_run_response", {24'd0, response}, 32'h55);

    // Equal bases force the collision rule on every bit, with wrap at k=5.
    do_run(6'b011_011, 16'd10, 1'b0);

    // Zero window behaves as one cycle; tie on bit 2.
    rand_tables(200);
    ta[2] = 8'd7; tbv[2] = 8'd7;
    do_run(6'b101_001, 16'd0, 1'b0);
    check("tie_sticky", {31'd0, tie}, 1);
    check("tie_bit_zero", {31'd0, response[2]}, 0);

    // Abort during RUN of bit 3.
    rand_tables(3);
    d0 = done_cnt;
    issue(6'b001_110, 16'd10, 1'b1);
    start = 1'b0;
    wait_bit_run(3);
    quiet = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    sel_q.delete();
    exp_q.delete();
    model(6'b001_110, 3, 1'b0, pr, pt);
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_osc_clr", {30'd0, osc_en, cnt_clr}, 0);
    check("abort_partial_resp", {24'd0, response}, {24'd0, pr});
    check("abort_partial_tie", {31'd0, tie}, {31'd0, pt});
    repeat (10) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);

    // Start held and challenge disturbed while busy.
    rand_tables(3);
    do_run(6'b100_010, 16'd5, 1'b1);

    // Reset during SETTLE, then a clean run.
    rand_tables(3);
    issue(6'b111_000, 16'd6, 1'b1);
    start = 1'b0;
    wait_bit_run(2);
    begin
      int n = 0;
      while (osc_en && n < 100) begin @(negedge clk); n++; end
    end
    quiet = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sel_q.delete();
    exp_q.delete();
    @(negedge clk);
    check_reset_outs("mid_rst");
    do_run(6'b110_011, 16'd4, 1'b0);

    // Randomized runs.
    for (int i = 0; i < 6; i++) begin
      rand_tables(3);
      do_run(6'($urandom), 16'($urandom_range(0, 12)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
